// File: rtl/tree_scheduler.sv
// -----------------------------------------------------------------------------
// tree_scheduler
//   Round-robin front end for a packet-classification decision tree. Two
//   requesters offer packed headers; the winner's header is registered, the
//   tree is launched with a one-cycle start pulse, its verdict is captured and
//   handed back through a valid/ready response channel together with the id of
//   the owning requester. Delivered and dropped verdicts are counted with
//   saturating 16-bit counters.
//
//   Optional feature (macro TREE_WDOG_EN): a watchdog that forces a drop
//   verdict with rsp_timeout=1 when the tree has not finished within
//   TIMEOUT_CYC WAIT cycles. Without the macro the watchdog is absent and
//   rsp_timeout is tied to 0.
//
// Ports
//   clk, rst_n                 rising-edge clock, asynchronous active-low reset
//   req0_valid/ready/hdr       requester 0 handshake and header
//   req1_valid/ready/hdr       requester 1 handshake and header
//   dt_start                   one-cycle launch pulse to the tree
//   dt_hdr                     registered header presented to the tree
//   dt_done, dt_drop           tree completion flag and verdict
//   rsp_valid, rsp_ready       verdict handshake
//   rsp_id, rsp_drop           owning requester and verdict (1 = drop)
//   rsp_timeout                verdict was produced by the watchdog
//   cnt_pkt, cnt_drop          verdicts delivered / drop verdicts delivered
// -----------------------------------------------------------------------------
module tree_scheduler #(
    parameter int HDR_W = 82
`ifdef TREE_WDOG_EN
    , parameter int TIMEOUT_CYC = 255
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [HDR_W-1:0] req0_hdr,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [HDR_W-1:0] req1_hdr,
    output logic             dt_start,
    output logic [HDR_W-1:0] dt_hdr,
    input  logic             dt_done,
    input  logic             dt_drop,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic             rsp_drop,
    output logic             rsp_timeout,
    output logic [15:0]      cnt_pkt,
    output logic [15:0]      cnt_drop
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic        ptr;          // requester that wins when both are valid
    logic        grant_id;     // arbitration winner this cycle
    logic        grant_any;
    logic        accept;
    logic        done_hit;     // tree finished while we were listening
    logic        timeout_hit;  // watchdog limit reached without dt_done
    logic        handshake;
    logic [15:0] cnt_pkt_q,  cnt_pkt_nxt;
    logic [15:0] cnt_drop_q, cnt_drop_nxt;

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid) grant_id = ptr;
        else                          grant_id = req1_valid;
    end

    assign accept    = (state == IDLE) && grant_any;
    assign done_hit  = (state == WAIT) && dt_done;
    assign handshake = (state == RESP) && rsp_ready;

`ifdef TREE_WDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            rsp_timeout_q;

    // The limit is reached in the TIMEOUT_CYC-th WAIT cycle (count runs from 0).
    assign timeout_hit = (state == WAIT) && !dt_done &&
                         (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt        <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            if ((state == WAIT) && !dt_done && !timeout_hit) wd_cnt <= wd_cnt + WD_W'(1);
            else                                             wd_cnt <= '0;

            if (done_hit)         rsp_timeout_q <= 1'b0;
            else if (timeout_hit) rsp_timeout_q <= 1'b1;
        end
    end

    assign rsp_timeout = rsp_timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and state-decoded outputs.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        dt_start   = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                // Gated by rst_n so the grant drops the instant reset asserts.
                req0_ready = rst_n && req0_valid && !grant_id;
                req1_ready = rst_n && req1_valid &&  grant_id;
                if (grant_any) state_nxt = LAUNCH;
            end
            LAUNCH: begin
                dt_start  = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (done_hit || timeout_hit) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                // Returning to IDLE here means no accept can share this edge.
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Header, id, pointer and verdict capture.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the datapath registers are reset as well, because dt_hdr and
        // the response fields must read 0 while reset is held.
        if (!rst_n) begin
            ptr      <= 1'b0;
            dt_hdr   <= '0;
            rsp_id   <= 1'b0;
            rsp_drop <= 1'b0;
        end else begin
            if (accept) begin
                dt_hdr <= grant_id ? req1_hdr : req0_hdr;
                rsp_id <= grant_id;
                ptr    <= ~grant_id;
            end
            if (done_hit)         rsp_drop <= dt_drop;
            else if (timeout_hit) rsp_drop <= 1'b1;
        end
    end

    // Saturating verdict counters.
    always_comb begin
        cnt_pkt_nxt  = cnt_pkt_q;
        cnt_drop_nxt = cnt_drop_q;
        if (handshake) begin
            if (cnt_pkt_q != 16'hFFFF)             cnt_pkt_nxt  = cnt_pkt_q + 16'd1;
            if (rsp_drop && cnt_drop_q != 16'hFFFF) cnt_drop_nxt = cnt_drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_pkt_q  <= '0;
            cnt_drop_q <= '0;
        end else begin
            cnt_pkt_q  <= cnt_pkt_nxt;
            cnt_drop_q <= cnt_drop_nxt;
        end
    end

    assign cnt_pkt  = cnt_pkt_q;
    assign cnt_drop = cnt_drop_q;

endmodule
